// File: rtl/zap_tlb_assoc_if.sv
// Lookup, fill and invalidate bundle for zap_tlb_assoc.
// The cache/page-walk side uses master; the TLB uses slave.
interface zap_tlb_assoc_if #(
  parameter int ENTRIES = 16
);
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic          i_hold;
  logic          i_lkp_valid;
  logic [31:0]   i_lkp_va;
  logic          o_hit;
  logic [31:0]   o_phy_addr;
  logic [7:0]    o_ap;
  logic [3:0]    o_dom;
  logic [1:0]    o_cb;
  logic [1:0]    o_size;
  logic          i_fill_valid;
  logic [31:0]   i_fill_va;
  logic [31:0]   i_fill_pa;
  logic [1:0]    i_fill_size;
  logic [7:0]    i_fill_ap;
  logic [3:0]    i_fill_dom;
  logic [1:0]    i_fill_cb;
  logic          i_inv_all;
  logic          i_inv_mva;
  logic [31:0]   i_inv_va;
  logic [IW-1:0] i_lock_base;
  logic          o_busy;

  modport master (
    output i_hold, i_lkp_valid, i_lkp_va,
    output i_fill_valid, i_fill_va, i_fill_pa, i_fill_size, i_fill_ap, i_fill_dom, i_fill_cb,
    output i_inv_all, i_inv_mva, i_inv_va, i_lock_base,
    input  o_hit, o_phy_addr, o_ap, o_dom, o_cb, o_size, o_busy
  );

  modport slave (
    input  i_hold, i_lkp_valid, i_lkp_va,
    input  i_fill_valid, i_fill_va, i_fill_pa, i_fill_size, i_fill_ap, i_fill_dom, i_fill_cb,
    input  i_inv_all, i_inv_mva, i_inv_va, i_lock_base,
    output o_hit, o_phy_addr, o_ap, o_dom, o_cb, o_size, o_busy
  );
endinterface

// File: rtl/zap_tlb_assoc.sv
// Fully associative unified TLB (section/large/small/tiny) with dedup fill,
// round-robin replacement and multi-cycle invalidate-by-MVA. Option: ZAP_TLB_LOCKDOWN_EN.
module zap_tlb_assoc #(
  parameter int ENTRIES = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  zap_tlb_assoc_if.slave tlb
);
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  // state | meaning
  // IDLE  | normal lookup/fill operation
  // CMP   | latched MVA compared against every entry under its own size
  // CLR   | matched valid bits cleared
  typedef enum logic [1:0] {S_IDLE, S_CMP, S_CLR} state_t;

  state_t state_q, state_d;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [21:0]        tag_q  [ENTRIES];
  logic [21:0]        pa_q   [ENTRIES];
  logic [1:0]         size_q [ENTRIES];
  logic [7:0]         ap_q   [ENTRIES];
  logic [3:0]         dom_q  [ENTRIES];
  logic [1:0]         cb_q   [ENTRIES];

  logic [IW-1:0]      rr_q, rr_d;
  logic [21:0]        inv_va_q, inv_va_d;
  logic [ENTRIES-1:0] mva_hit_q, mva_hit_d;

  logic               hit_q, hit_d;
  logic [31:0]        phy_q, phy_d;
  logic [7:0]         oap_q, oap_d;
  logic [3:0]         odom_q, odom_d;
  logic [1:0]         ocb_q, ocb_d;
  logic [1:0]         osize_q, osize_d;

  logic               busy;
  logic               lkp_hit;
  logic [IW-1:0]      lkp_idx;
  logic [21:0]        fill_tag;
  logic               dup_hit, free_hit, base_ok;
  logic [IW-1:0]      dup_idx, free_idx, vic, base, rr_nxt;
  logic [ENTRIES-1:0] repl;
  logic               wr_en;
  logic [IW-1:0]      wr_idx;

  function automatic logic tag_match(input logic [21:0] tag, input logic [1:0] sz,
                                     input logic [31:0] va);
    case (sz)
      2'b00:   return tag[21:10] == va[31:20];
      2'b01:   return tag[21:6]  == va[31:16];
      2'b10:   return tag[21:2]  == va[31:12];
      default: return tag        == va[31:10];
    endcase
  endfunction

  // Tags are stored with the in-page bits zeroed so dedup is a plain equality.
  function automatic logic [21:0] tag_mask(input logic [31:0] va, input logic [1:0] sz);
    case (sz)
      2'b00:   return {va[31:20], 10'b0};
      2'b01:   return {va[31:16], 6'b0};
      2'b10:   return {va[31:12], 2'b0};
      default: return va[31:10];
    endcase
  endfunction

  function automatic logic [31:0] compose_pa(input logic [21:0] pa, input logic [1:0] sz,
                                             input logic [31:0] va);
    case (sz)
      2'b00:   return {pa[21:10], va[19:0]};
      2'b01:   return {pa[21:6],  va[15:0]};
      2'b10:   return {pa[21:2],  va[11:0]};
      default: return {pa,        va[9:0]};
    endcase
  endfunction

  assign busy     = (state_q != S_IDLE);
  assign fill_tag = tag_mask(tlb.i_fill_va, tlb.i_fill_size);

`ifdef ZAP_TLB_LOCKDOWN_EN
  always_comb begin
    repl = '0;
    for (int i = 0; i < ENTRIES; i++)
      repl[i] = ({1'b0, tlb.i_lock_base} <= (IW+1)'(i));
  end
  assign base_ok = ({1'b0, tlb.i_lock_base} < (IW+1)'(ENTRIES));
  assign base    = tlb.i_lock_base;
  assign vic     = (rr_q < tlb.i_lock_base) ? tlb.i_lock_base : rr_q;
`else
  logic unused_ok;
  assign repl      = '1;
  assign base_ok   = 1'b1;
  assign base      = '0;
  assign vic       = rr_q;
  assign unused_ok = ^tlb.i_lock_base;
`endif

  logic unused_bits;
  assign unused_bits = ^{tlb.i_fill_va[9:0], tlb.i_fill_pa[9:0], tlb.i_inv_va[9:0]};

  assign rr_nxt = (vic == IW'(ENTRIES-1)) ? base : vic + 1'b1;

  // Descending scans leave the lowest matching index as the winner.
  always_comb begin
    lkp_hit  = 1'b0;
    lkp_idx  = '0;
    dup_hit  = 1'b0;
    dup_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (valid_q[i] && tag_match(tag_q[i], size_q[i], tlb.i_lkp_va)) begin
        lkp_hit = 1'b1;
        lkp_idx = IW'(i);
      end
      if (valid_q[i] && tag_q[i] == fill_tag && size_q[i] == tlb.i_fill_size) begin
        dup_hit = 1'b1;
        dup_idx = IW'(i);
      end
      if (!valid_q[i] && repl[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    hit_d   = hit_q;
    phy_d   = phy_q;
    oap_d   = oap_q;
    odom_d  = odom_q;
    ocb_d   = ocb_q;
    osize_d = osize_q;
    if (!tlb.i_hold) begin
      hit_d   = tlb.i_lkp_valid & lkp_hit & ~busy;
      phy_d   = '0;
      oap_d   = '0;
      odom_d  = '0;
      ocb_d   = '0;
      osize_d = '0;
      if (hit_d) begin
        phy_d   = compose_pa(pa_q[lkp_idx], size_q[lkp_idx], tlb.i_lkp_va);
        oap_d   = ap_q[lkp_idx];
        odom_d  = dom_q[lkp_idx];
        ocb_d   = cb_q[lkp_idx];
        osize_d = size_q[lkp_idx];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    rr_d      = rr_q;
    inv_va_d  = inv_va_q;
    mva_hit_d = mva_hit_q;
    wr_en     = 1'b0;
    wr_idx    = '0;

    if (tlb.i_fill_valid && !busy && !tlb.i_inv_all) begin
      if (dup_hit) begin
        wr_en  = 1'b1;
        wr_idx = dup_idx;
      end else if (free_hit) begin
        wr_en  = 1'b1;
        wr_idx = free_idx;
      end else if (base_ok) begin
        wr_en  = 1'b1;
        wr_idx = vic;
        if (!tlb.i_hold) rr_d = rr_nxt;
      end
    end
    if (wr_en) valid_d[wr_idx] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tlb.i_inv_mva) begin
          state_d  = S_CMP;
          inv_va_d = tlb.i_inv_va[31:10];
        end
      end
      S_CMP: begin
        for (int i = 0; i < ENTRIES; i++)
          mva_hit_d[i] = valid_q[i] && tag_match(tag_q[i], size_q[i], {inv_va_q, 10'b0});
        state_d = S_CLR;
      end
      S_CLR: begin
        valid_d = valid_q & ~mva_hit_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Invalidate-all overrides both a fill and an in-flight MVA clear.
    if (tlb.i_inv_all) begin
      state_d = S_IDLE;
      valid_d = valid_q & ~repl;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      rr_q      <= '0;
      inv_va_q  <= '0;
      mva_hit_q <= '0;
      hit_q     <= 1'b0;
      phy_q     <= '0;
      oap_q     <= '0;
      odom_q    <= '0;
      ocb_q     <= '0;
      osize_q   <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      rr_q      <= rr_d;
      inv_va_q  <= inv_va_d;
      mva_hit_q <= mva_hit_d;
      hit_q     <= hit_d;
      phy_q     <= phy_d;
      oap_q     <= oap_d;
      odom_q    <= odom_d;
      ocb_q     <= ocb_d;
      osize_q   <= osize_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= fill_tag;
      pa_q[wr_idx]   <= tlb.i_fill_pa[31:10];
      size_q[wr_idx] <= tlb.i_fill_size;
      ap_q[wr_idx]   <= tlb.i_fill_ap;
      dom_q[wr_idx]  <= tlb.i_fill_dom;
      cb_q[wr_idx]   <= tlb.i_fill_cb;
    end
  end

  assign tlb.o_hit      = hit_q;
  assign tlb.o_phy_addr = phy_q;
  assign tlb.o_ap       = oap_q;
  assign tlb.o_dom      = odom_q;
  assign tlb.o_cb       = ocb_q;
  assign tlb.o_size     = osize_q;
  assign tlb.o_busy     = busy;
endmodule

// File: tb/tb_zap_tlb_assoc.sv
// Directed bench for zap_tlb_assoc with ENTRIES=4; the lockdown scenario
// runs only when ZAP_TLB_LOCKDOWN_EN is defined.
module tb_zap_tlb_assoc;
  localparam int ENTRIES = 4;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  zap_tlb_assoc_if #(.ENTRIES(ENTRIES)) bus ();

  zap_tlb_assoc #(.ENTRIES(ENTRIES)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .tlb     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] va, input logic [31:0] pa, input logic [1:0] sz);
    bus.i_fill_valid = 1'b1;
    bus.i_fill_va    = va;
    bus.i_fill_pa    = pa;
    bus.i_fill_size  = sz;
    bus.i_fill_ap    = 8'hA5;
    bus.i_fill_dom   = 4'h3;
    bus.i_fill_cb    = 2'b10;
    tick();
    bus.i_fill_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] va);
    bus.i_lkp_valid = 1'b1;
    bus.i_lkp_va    = va;
    tick();
    bus.i_lkp_valid = 1'b0;
  endtask

  task automatic chk_lkp(input string tag, input logic [31:0] va, input logic exp_hit,
                         input logic [31:0] exp_pa);
    lookup(va);
    chk({tag, "_hit"}, {31'b0, bus.o_hit}, {31'b0, exp_hit});
    chk({tag, "_pa"}, bus.o_phy_addr, exp_pa);
  endtask

  task automatic pulse_inv_all();
    bus.i_inv_all = 1'b1;
    tick();
    bus.i_inv_all = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_hold       = 1'b0;
    bus.i_lkp_valid  = 1'b0;
    bus.i_lkp_va     = '0;
    bus.i_fill_valid = 1'b0;
    bus.i_fill_va    = '0;
    bus.i_fill_pa    = '0;
    bus.i_fill_size  = '0;
    bus.i_fill_ap    = '0;
    bus.i_fill_dom   = '0;
    bus.i_fill_cb    = '0;
    bus.i_inv_all    = 1'b0;
    bus.i_inv_mva    = 1'b0;
    bus.i_inv_va     = '0;
    bus.i_lock_base  = '0;

    #3;
    chk("rst_hit",  {31'b0, bus.o_hit}, 32'd0);
    chk("rst_pa",   bus.o_phy_addr, 32'd0);
    chk("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("rst_attr", {16'b0, bus.o_ap, bus.o_dom, bus.o_cb, bus.o_size}, 32'd0);
    #10;
    rst = 1'b0;
    tick();

    // small page
    fill(32'h0000_3000, 32'h8000_5000, 2'b10);
    chk_lkp("small", 32'h0000_3ABC, 1'b1, 32'h8000_5ABC);
    chk("small_size", {30'b0, bus.o_size}, 32'd2);
    chk("small_attr", {18'b0, bus.o_ap, bus.o_dom, bus.o_cb}, {18'b0, 8'hA5, 4'h3, 2'b10});

    // section page, inside and just past the boundary
    fill(32'h1230_0000, 32'h4560_0000, 2'b00);
    chk_lkp("sec_in", 32'h123F_FFFC, 1'b1, 32'h456F_FFFC);
    chk("sec_size", {30'b0, bus.o_size}, 32'd0);
    chk_lkp("sec_out", 32'h1240_0000, 1'b0, 32'h0);
    chk("miss_attr", {16'b0, bus.o_ap, bus.o_dom, bus.o_cb, bus.o_size}, 32'd0);

    // fill and lookup in the same cycle: lookup sees pre-fill contents
    bus.i_lkp_valid = 1'b1;
    bus.i_lkp_va    = 32'h0005_1234;
    fill(32'h0005_0000, 32'h0009_0000, 2'b01);
    bus.i_lkp_valid = 1'b0;
    chk("same_cyc_hit", {31'b0, bus.o_hit}, 32'd0);
    chk_lkp("large", 32'h0005_1234, 1'b1, 32'h0009_1234);
    chk("large_size", {30'b0, bus.o_size}, 32'd1);

    // hold freezes the outputs
    bus.i_hold = 1'b1;
    chk_lkp("hold", 32'h0000_3ABC, 1'b1, 32'h0009_1234);
    bus.i_hold = 1'b0;
    tick();
    chk("idle_hit", {31'b0, bus.o_hit}, 32'd0);
    chk("idle_pa", bus.o_phy_addr, 32'd0);

    pulse_inv_all();
    chk_lkp("inv_all_small", 32'h0000_3ABC, 1'b0, 32'h0);
    chk_lkp("inv_all_sec", 32'h1230_0000, 1'b0, 32'h0);

    // round robin over tiny pages; pointer is still 0
    for (int k = 0; k < 5; k++)
      fill(32'h000A_0400 + 32'(k) * 32'h400, 32'h00B0_0400 + 32'(k) * 32'h400, 2'b11);
    chk_lkp("rr_t0", 32'h000A_043C, 1'b0, 32'h0);
    for (int k = 1; k < 5; k++)
      chk_lkp($sformatf("rr_t%0d", k), 32'h000A_043C + 32'(k) * 32'h400, 1'b1,
              32'h00B0_043C + 32'(k) * 32'h400);

    // dedup refill of T2, then T5 must evict entry 1 (T1)
    fill(32'h000A_0C00, 32'h00C0_0000, 2'b11);
    chk_lkp("dedup_t2", 32'h000A_0C3C, 1'b1, 32'h00C0_003C);
    fill(32'h000A_1800, 32'h00B0_1800, 2'b11);
    chk_lkp("vic_t1", 32'h000A_083C, 1'b0, 32'h0);
    chk_lkp("keep_t2", 32'h000A_0C3C, 1'b1, 32'h00C0_003C);
    chk_lkp("new_t5", 32'h000A_1810, 1'b1, 32'h00B0_1810);

    // victimising fill under hold leaves the pointer at 2
    bus.i_hold = 1'b1;
    fill(32'h000A_1C00, 32'h00B0_1C00, 2'b11);
    bus.i_hold = 1'b0;
    fill(32'h000A_2000, 32'h00B0_2000, 2'b11);
    chk_lkp("hold_t6", 32'h000A_1C00, 1'b0, 32'h0);
    chk_lkp("hold_t7", 32'h000A_2004, 1'b1, 32'h00B0_2004);
    chk_lkp("hold_t3", 32'h000A_1000, 1'b1, 32'h00B0_1000);
    chk_lkp("hold_t2", 32'h000A_0C00, 1'b0, 32'h0);

    // invalidate by MVA
    pulse_inv_all();
    fill(32'h0010_0000, 32'h0030_0000, 2'b00);
    fill(32'h0020_0000, 32'h0040_0000, 2'b00);
    bus.i_inv_mva = 1'b1;
    bus.i_inv_va  = 32'h0010_0400;
    tick();
    bus.i_inv_mva = 1'b0;
    chk("mva_busy1", {31'b0, bus.o_busy}, 32'd1);
    bus.i_lkp_valid = 1'b1;
    bus.i_lkp_va    = 32'h0020_0000;
    fill(32'h0050_0000, 32'h0060_0000, 2'b00);
    chk("mva_busy2", {31'b0, bus.o_busy}, 32'd1);
    chk("mva_busy_hit", {31'b0, bus.o_hit}, 32'd0);
    bus.i_lkp_valid = 1'b0;
    tick();
    chk("mva_busy3", {31'b0, bus.o_busy}, 32'd0);
    chk_lkp("mva_first", 32'h0010_0000, 1'b0, 32'h0);
    chk_lkp("mva_drop_fill", 32'h0050_0000, 1'b0, 32'h0);
    chk_lkp("mva_second", 32'h0020_0010, 1'b1, 32'h0040_0010);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hit", {31'b0, bus.o_hit}, 32'd0);
    chk("arst_pa", bus.o_phy_addr, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk_lkp("arst_valid", 32'h0020_0010, 1'b0, 32'h0);

`ifdef ZAP_TLB_LOCKDOWN_EN
    bus.i_lock_base = 2'd0;
    for (int k = 0; k < 2; k++)
      fill(32'h0100_0000 + (32'(k) << 20), 32'h0A00_0000 + (32'(k) << 20), 2'b00);
    bus.i_lock_base = 2'd2;
    for (int k = 2; k < 6; k++)
      fill(32'h0100_0000 + (32'(k) << 20), 32'h0A00_0000 + (32'(k) << 20), 2'b00);
    chk_lkp("lock_pre_l0", 32'h0100_0040, 1'b1, 32'h0A00_0040);
    chk_lkp("lock_pre_l2", 32'h0120_0040, 1'b0, 32'h0);
    pulse_inv_all();
    chk_lkp("lock_l0", 32'h0100_0040, 1'b1, 32'h0A00_0040);
    chk_lkp("lock_l1", 32'h0110_0080, 1'b1, 32'h0A10_0080);
    chk_lkp("lock_l4", 32'h0140_0000, 1'b0, 32'h0);
    chk_lkp("lock_l5", 32'h0150_0000, 1'b0, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
